tlc_phase_sequencer: RTL and testbench

TLC_PHASE_SEQUENCER -- requirements
Module: tlc_phase_sequencer

---
 rtl/tlc_phase_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_tlc_phase_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_sequencer.sv
// Multi-phase traffic signal sequencer: demand/recall phase service, emergency
// preemption and night flash, with per-phase demand latch and lamp decode lanes.

module tlc_phase_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       grant,
  input  logic       sel,
  input  logic       grn,
  input  logic       yel,
  input  logic       flash_on,
  output logic       pending,
  output logic [1:0] light
);
  // A request arriving on the same cycle the phase is granted is dropped.
  always_ff @(posedge clk)
    if (rst)        pending <= 1'b0;
    else if (grant) pending <= 1'b0;
    else if (req)   pending <= 1'b1;

  always_comb begin
    light = 2'b00;
    if (flash_on)         light = 2'b01;
    else if (sel && grn)  light = 2'b10;
    else if (sel && yel)  light = 2'b01;
  end
endmodule

module tlc_phase_sequencer #(
  parameter int NUM_PHASES   = 4,
  parameter int TW           = 8,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int FLASH_HALF   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PHASES*TW-1:0]   green_time,
  input  logic [NUM_PHASES-1:0]      req,
  input  logic [NUM_PHASES-1:0]      recall,
  input  logic                       emg_req,
  input  logic [$clog2(NUM_PHASES)-1:0] emg_phase,
  input  logic                       flash_en,
  output logic [2*NUM_PHASES-1:0]    light,
  output logic [$clog2(NUM_PHASES)-1:0] phase,
  output logic [2:0]                 ps,
  output logic [TW-1:0]              count,
  output logic                       preempt_active
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] Y_LAST  = (YELLOW_TIME  < 1) ? '0 : TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST = (ALL_RED_TIME < 1) ? '0 : TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] F_LAST  = (FLASH_HALF   < 1) ? '0 : TW'(2*FLASH_HALF - 1);
  localparam logic [TW-1:0] F_HALF  = TW'(FLASH_HALF);

  typedef enum logic [2:0] {
    S_ALL_RED = 3'd0, S_GREEN = 3'd1, S_YELLOW = 3'd2, S_PREEMPT = 3'd3, S_FLASH = 3'd4
  } state_t;

  state_t                st, st_nx;
  logic [PW-1:0]         phase_nx, tgt, tgt_nx, nxt_ph;
  logic [TW-1:0]         count_nx, gdur, gdur_nx, g_last;
  logic                  emg_seen, emg_seen_nx, emg_now, nxt_found;
  logic [NUM_PHASES-1:0] pending, grant, svc;

  // tgt holds the phase the next ALL_RED expiry will hand green to.
  always_ff @(posedge clk)
    if (rst) begin
      st       <= S_ALL_RED;
      phase    <= '0;
      count    <= '0;
      gdur     <= '0;
      tgt      <= '0;
      emg_seen <= 1'b0;
    end else begin
      st       <= st_nx;
      phase    <= phase_nx;
      count    <= count_nx;
      gdur     <= gdur_nx;
      tgt      <= tgt_nx;
      emg_seen <= emg_seen_nx;
    end

  assign svc = pending | recall;

  // Cyclic search from phase+1; descending loop lets the nearest candidate win.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ph    = phase;
    for (int k = NUM_PHASES - 1; k >= 1; k--)
      if (svc[(int'(phase) + k) % NUM_PHASES]) begin
        nxt_found = 1'b1;
        nxt_ph    = PW'((int'(phase) + k) % NUM_PHASES);
      end
  end

  assign g_last  = (gdur == '0) ? '0 : gdur - ONE;
  assign emg_now = emg_req | emg_seen;

  always_comb begin
    st_nx    = st;
    phase_nx = phase;
    count_nx = count + ONE;
    gdur_nx  = gdur;
    tgt_nx   = tgt;
    grant    = '0;
    case (st)
      S_ALL_RED:
        if (count == AR_LAST) begin
          count_nx = '0;
          if (emg_now) begin
            st_nx    = S_PREEMPT;
            phase_nx = emg_phase;
          end else if (flash_en) begin
            st_nx = S_FLASH;
          end else begin
            st_nx      = S_GREEN;
            phase_nx   = tgt;
            gdur_nx    = green_time[int'(tgt)*TW +: TW];
            grant[tgt] = 1'b1;
          end
        end
      S_GREEN:
        if (emg_req) begin
          count_nx = '0;
          st_nx    = (phase == emg_phase) ? S_PREEMPT : S_YELLOW;
        end else if (count == g_last) begin
          if (nxt_found) begin
            st_nx    = S_YELLOW;
            count_nx = '0;
            tgt_nx   = nxt_ph;
          end else begin
            count_nx = count;
          end
        end
      S_YELLOW:
        if (count == Y_LAST) begin
          st_nx    = S_ALL_RED;
          count_nx = '0;
        end
      S_PREEMPT:
        if (!emg_req) begin
          st_nx    = S_YELLOW;
          count_nx = '0;
          tgt_nx   = nxt_found ? nxt_ph : phase;
        end else if (&count) begin
          count_nx = count;
        end
      S_FLASH:
        if (emg_now || !flash_en) begin
          st_nx    = S_ALL_RED;
          count_nx = '0;
          tgt_nx   = '0;
        end else if (count == F_LAST) begin
          count_nx = '0;
        end
      default: begin
        st_nx    = S_ALL_RED;
        count_nx = '0;
      end
    endcase
    // Emergency seen while clearing is remembered until PREEMPT is reached.
    emg_seen_nx = (st_nx == S_PREEMPT) ? 1'b0 : emg_now;
  end

  assign ps             = st;
  assign preempt_active = (st == S_PREEMPT);

  genvar i;
  generate
    for (i = 0; i < NUM_PHASES; i++) begin : g_lane
      tlc_phase_lane u_lane (
        .clk      (clk),
        .rst      (rst),
        .req      (req[i]),
        .grant    (grant[i]),
        .sel      (phase == PW'(i)),
        .grn      ((st == S_GREEN) || (st == S_PREEMPT)),
        .yel      (st == S_YELLOW),
        .flash_on ((st == S_FLASH) && (count < F_HALF)),
        .pending  (pending[i]),
        .light    (light[2*i +: 2])
      );
    end
  endgenerate
endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Directed bench for tlc_phase_sequencer: per-cycle expected snapshots go
// through a scoreboard queue and are checked with immediate assertions.

module tb_tlc_phase_sequencer;
  localparam int NP = 4;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP*TW-1:0] green_time = {NP{8'd5}};
  logic [NP-1:0]   req = '0;
  logic [NP-1:0]   recall = '0;
  logic            emg_req = 1'b0;
  logic [1:0]      emg_phase = '0;
  logic            flash_en = 1'b0;
  logic [2*NP-1:0] light;
  logic [1:0]      phase;
  logic [2:0]      ps;
  logic [TW-1:0]   count;
  logic            preempt_active;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mark     = 0;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tlc_phase_sequencer #(
    .NUM_PHASES(NP), .TW(TW), .YELLOW_TIME(3), .ALL_RED_TIME(2), .FLASH_HALF(4)
  ) dut (
    .clk(clk), .rst(rst), .green_time(green_time), .req(req), .recall(recall),
    .emg_req(emg_req), .emg_phase(emg_phase), .flash_en(flash_en),
    .light(light), .phase(phase), .ps(ps), .count(count), .preempt_active(preempt_active)
  );

  function automatic logic [7:0] lt(input logic [1:0] code, input int p);
    logic [7:0] v;
    v = '0;
    v[2*p +: 2] = code;
    return v;
  endfunction

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (ps,phase,count,light,pa)", tag, obs, expv);
    end
  endtask

  // Queue the expected snapshot for the next edge, then compare after it.
  task automatic step(input string tag, input logic [2:0] eps, input int eph,
                      input int ecnt, input logic [7:0] elt);
    exp_t e;
    logic [1:0] ph2;
    logic [7:0] c8;
    ph2 = eph[1:0];
    c8  = ecnt[7:0];
    e.tag = tag;
    e.v   = {eps, ph2, c8, elt, eps == 3'd3};
    sb.push_back(e);
    @(posedge clk); #1;
    cyc++;
    e = sb.pop_front();
    check(e.tag, {ps, phase, count, light, preempt_active}, e.v);
  endtask

  task automatic green(input int p, input int from, input int to);
    for (int c = from; c <= to; c++) step("green", 3'd1, p, c, lt(2'b10, p));
  endtask

  task automatic yellow(input int p);
    for (int c = 0; c < 3; c++) step("yellow", 3'd2, p, c, lt(2'b01, p));
  endtask

  task automatic allred(input int p);
    for (int c = 0; c < 2; c++) step("allred", 3'd0, p, c, 8'h00);
  endtask

  task automatic do_reset(input logic [3:0] rc, input logic fl);
    rst = 1'b1; recall = rc; flash_en = fl; req = '0;
    emg_req = 1'b0; emg_phase = '0; green_time = {NP{8'd5}};
    repeat (2) @(posedge clk);
    #1;
    check("reset", {ps, phase, count, light, preempt_active}, 22'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Full recall rotation, period, then emergency preempt of phase 1 -> 3
    do_reset(4'b1111, 1'b0);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 0);
    mark = cyc;
    green(0, 1, 4); yellow(0); allred(0);
    for (int p = 1; p < 4; p++) begin
      green(p, 0, 4); yellow(p); allred(p);
    end
    green(0, 0, 0);
    n_assert++;
    assert (cyc - mark == 40) else begin
      n_fail++;
      $error("FAIL period: observed %0d expected 40", cyc - mark);
    end
    green(0, 1, 4); yellow(0); allred(0);
    green(1, 0, 1);
    emg_req = 1'b1; emg_phase = 2'd3;
    yellow(1); allred(1);
    for (int c = 0; c < 4; c++) step("preempt", 3'd3, 3, c, lt(2'b10, 3));
    emg_req = 1'b0;
    yellow(3); allred(3);
    green(0, 0, 0);

    // Demand service: req[2] only, phases 1 and 3 skipped
    do_reset(4'b0001, 1'b0);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 0);
    req = 4'b0100;
    green(0, 1, 1);
    req = '0;
    green(0, 2, 4); yellow(0); allred(0);
    green(2, 0, 4); yellow(2); allred(2);
    green(0, 0, 4);
    for (int k = 0; k < 3; k++) step("rest_after_demand", 3'd1, 0, 4, 8'b00_00_00_10);

    // Rest in phase 0, then same-phase preempt
    do_reset(4'b0001, 1'b0);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 4);
    for (int k = 0; k < 4; k++) step("rest", 3'd1, 0, 4, 8'b00_00_00_10);
    emg_req = 1'b1; emg_phase = 2'd0;
    step("preempt_same", 3'd3, 0, 0, lt(2'b10, 0));
    step("preempt_same", 3'd3, 0, 1, lt(2'b10, 0));
    emg_req = 1'b0;
    yellow(0);

    // Night flash
    do_reset(4'b1111, 1'b1);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    for (int c = 0; c < 8; c++) step("flash", 3'd4, 0, c, (c < 4) ? 8'h55 : 8'h00);
    for (int c = 0; c < 4; c++) step("flash_wrap", 3'd4, 0, c, 8'h55);
    flash_en = 1'b0;
    allred(0);
    green(0, 0, 0);

    // Reset mid-yellow on phase 2 with phase 3 pending
    do_reset(4'b0001, 1'b0);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 0);
    req = 4'b0100;
    green(0, 1, 1);
    req = '0;
    green(0, 2, 4); yellow(0); allred(0);
    green(2, 0, 4);
    step("yellow2", 3'd2, 2, 0, lt(2'b01, 2));
    req = 4'b1000;
    step("yellow2", 3'd2, 2, 1, lt(2'b01, 2));
    req = '0;
    rst = 1'b1;
    step("rst_mid_yellow", 3'd0, 0, 0, 8'h00);
    rst = 1'b0;
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 4);
    for (int k = 0; k < 4; k++) step("pending_cleared", 3'd1, 0, 4, 8'b00_00_00_10);

    // Green time latched on entry; zero green treated as one cycle
    do_reset(4'b0011, 1'b0);
    step("ar_after_rst", 3'd0, 0, 1, 8'h00);
    green(0, 0, 0);
    green_time = {8'd5, 8'd5, 8'd0, 8'd2};
    green(0, 1, 4); yellow(0); allred(0);
    green(1, 0, 0); yellow(1); allred(1);
    green(0, 0, 1); yellow(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
